// File: rtl/mips_dmem_responder.sv
// mips_dmem_responder
//
// Memory-side responder for the core's load/store port. It holds a
// word-organized data RAM behind a valid/ready request channel and a
// valid/ready response channel. Every request takes a fixed, programmable
// number of clock edges to be serviced. Only one request is in flight at a
// time.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words (legal word index 0..DEPTH_WORDS-1)
//   LATENCY      edges from request acceptance to response valid (1..15)
//
// Ports
//   clk         in   1   clock, rising edge
//   resetN      in   1   asynchronous, active-low reset
//   req_valid   in   1   request present
//   req_ready   out  1   responder can accept a request (IDLE only)
//   req_we      in   1   1 = store, 0 = load
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data
//   req_be      in   4   store byte enables, be[i] covers wdata[8i+7:8i]
//   resp_valid  out  1   response present (RESP only)
//   resp_ready  in   1   requester accepts response
//   resp_rdata  out  32  load data, 0 for stores and errors
//   resp_err    out  1   request was misaligned or out of range

module mips_dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  // Index width into the RAM; kept at least 1 bit so a 1-word RAM still elaborates.
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);
  localparam logic [3:0]  CNT_INIT    = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t next_state;

  logic [3:0]  cnt;

  // Request fields captured on the acceptance edge; the request bus is
  // ignored afterwards.
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] mem [0:DEPTH_WORDS-1];

  logic          accept;
  logic          access;
  logic          handshake;
  logic          addr_err;
  logic [AW-1:0] word_idx;
  logic [31:0]   cur_word;
  logic [31:0]   merged_word;

  assign accept    = req_valid && req_ready;
  assign access    = (state == WAIT) && (cnt == 4'd0);
  assign handshake = (state == RESP) && resp_ready;

  // Decode is done on the latched address, so the result is fixed for the
  // whole lifetime of the request.
  assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_LIMIT);
  assign word_idx = addr_q[AW+1:2];
  assign cur_word = mem[word_idx];

  // Byte-lane merge for stores: lanes with be clear keep the old contents.
  always_comb begin
    merged_word = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (be_q[i]) begin
        merged_word[8*i +: 8] = wdata_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and handshake outputs. req_ready/resp_valid are pure state
  // decodes, so they drop to their reset values the moment resetN falls.
  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          next_state = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request capture, latency countdown and response data registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
        cnt     <= CNT_INIT;
      end else if ((state == WAIT) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      if (access) begin
        resp_err   <= addr_err;
        resp_rdata <= (!addr_err && !we_q) ? cur_word : 32'd0;
      end else if (handshake) begin
        resp_rdata <= 32'd0;
        resp_err   <= 1'b0;
      end
    end
  end

  // RAM: cleared by reset, written only on the access edge of a good store.
  // A store aborted by reset before its access edge therefore never lands.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (access && we_q && !addr_err) begin
      mem[word_idx] <= merged_word;
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// tb_mips_dmem_responder
//
// Self-checking bench for mips_dmem_responder. One instance runs with
// LATENCY=2 and is driven from a table of load/store vectors plus
// hand-written back-pressure and reset-abort sequences. A second instance
// runs with LATENCY=1 to check back-to-back request spacing.

module tb_mips_dmem_responder;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        req_valid1 = 1'b0;
  logic        req_ready1;
  logic        req_we1 = 1'b0;
  logic [31:0] req_addr1 = 32'h0000_0004;
  logic [31:0] req_wdata1 = 32'd0;
  logic [3:0]  req_be1 = 4'd0;
  logic        resp_valid1;
  logic        resp_ready1 = 1'b1;
  logic [31:0] resp_rdata1;
  logic        resp_err1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk        (clk),
    .resetN     (resetN),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_be     (req_be),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  mips_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .clk        (clk),
    .resetN     (resetN),
    .req_valid  (req_valid1),
    .req_ready  (req_ready1),
    .req_we     (req_we1),
    .req_addr   (req_addr1),
    .req_wdata  (req_wdata1),
    .req_be     (req_be1),
    .resp_valid (resp_valid1),
    .resp_ready (resp_ready1),
    .resp_rdata (resp_rdata1),
    .resp_err   (resp_err1)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Runs one complete transaction on the LATENCY=2 instance. Called at
  // posedge+1 with the DUT idle; returns at posedge+1 after the handshake.
  task automatic applyStimulus(input vec_t v, input string tag);
    int edges;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_be    = v.be;
    req_valid = 1'b1;
    checkOutput({tag, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    // Scramble the request bus: the DUT must use what it latched.
    req_valid = 1'b0;
    req_we    = ~v.we;
    req_addr  = 32'h0000_0000;
    req_wdata = ~v.wdata;
    req_be    = ~v.be;
    edges = 0;
    while (!resp_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput({tag, " latency"}, 32'(edges), 32'd2);
    checkOutput({tag, " rdata"}, resp_rdata, v.exp_rdata);
    checkOutput({tag, " err"}, 32'(resp_err), 32'(v.exp_err));
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checkOutput({tag, " resp_valid after handshake"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    int edges;
    int seen;
    int accepts;
    int last_accept;
    int cyc;
    logic prev_ready;

    vecs[0]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0020, 32'h0000_00AA, 4'h1, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0022, 32'h0,         4'h0, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0,         1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0020, 32'h1111_1111, 4'h0, 32'h0,         1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0};
    vecs[10] = '{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 4'hA, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 32'hCA00_F000, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_03FD, 32'h5555_5555, 4'hF, 32'h0,         1'b1};
    vecs[13] = '{1'b0, 32'h0000_03FC, 32'h0,         4'h0, 32'h0,         1'b0};

    #2;
    resetN = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset req_ready", 32'(req_ready), 32'd1);
    checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset rdata", resp_rdata, 32'd0);
    checkOutput("reset err", 32'(resp_err), 32'd0);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-pressure: response must hold steady while resp_ready is low.
    req_we    = 1'b0;
    req_addr  = 32'h0000_0020;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    edges = 0;
    while (!resp_valid && edges < 20) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("bp latency", 32'(edges), 32'd2);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp cyc%0d resp_valid", c), 32'(resp_valid), 32'd1);
      checkOutput($sformatf("bp cyc%0d rdata", c), resp_rdata, 32'hDEAD_BEAA);
      checkOutput($sformatf("bp cyc%0d req_ready", c), 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    checkOutput("bp release req_ready", 32'(req_ready), 32'd1);
    checkOutput("bp release resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("bp release rdata", resp_rdata, 32'd0);

    // Reset during WAIT aborts the store and discards its response.
    req_we    = 1'b1;
    req_addr  = 32'h0000_0008;
    req_wdata = 32'h1234_5678;
    req_be    = 4'hF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checkOutput("abort in WAIT req_ready", 32'(req_ready), 32'd0);
    resetN = 1'b0;
    #1;
    checkOutput("abort async req_ready", 32'(req_ready), 32'd1);
    checkOutput("abort async resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    resetN = 1'b1;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen++;
    end
    checkOutput("abort stray resp_valid", 32'(seen), 32'd0);
    applyStimulus('{1'b0, 32'h0000_0008, 32'h0, 4'h0, 32'h0, 1'b0}, "abort load 0x8");
    applyStimulus('{1'b0, 32'h0000_0020, 32'h0, 4'h0, 32'h0, 1'b0}, "reset cleared 0x20");

    // LATENCY=1 instance with req_valid held high: accepts every 3 edges.
    cyc = 0;
    accepts = 0;
    last_accept = -100;
    req_valid1 = 1'b1;
    prev_ready = req_ready1;
    for (int k = 0; k < 13; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == last_accept + 1) begin
        checkOutput($sformatf("l1 acc%0d resp_valid", accepts), 32'(resp_valid1), 32'd1);
        checkOutput($sformatf("l1 acc%0d rdata", accepts), resp_rdata1, 32'd0);
      end
      if (prev_ready) begin
        if (accepts > 0) begin
          checkOutput($sformatf("l1 acc%0d spacing", accepts), 32'(cyc - last_accept), 32'd3);
        end
        checkOutput($sformatf("l1 acc%0d resp_valid at accept", accepts), 32'(resp_valid1), 32'd0);
        last_accept = cyc;
        accepts++;
      end
      prev_ready = req_ready1;
    end
    req_valid1 = 1'b0;
    checkOutput("l1 accept count", 32'(accepts), 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
